// File: rtl/inst_fetch.sv
// Three-stage instruction fetch: S1 issues the ICache read, S2 captures the
// returned word, S3 presents it to decode. Stall backs up from S3; flush kills all.
module inst_fetch #(
  parameter int unsigned DATA = 32,
  parameter int unsigned ADDR = 12
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [31:0]     PC_in_IF_PC,
  input  logic            GRT_RR_IF,
  input  logic            Flush_PC_IF,
  input  logic            Stall_ID_IF,
  input  logic [DATA-1:0] Data_ICache_IF,
  output logic            Rd_IF_ICache,
  output logic [ADDR-1:0] Addr_IF_ICache,
  output logic [DATA-1:0] Inst_IF_ID,
  output logic [31:0]     PC_IF_ID,
  output logic            Valid_IF_ID,
  output logic            valid_1_IF_PC,
  output logic            valid_2_IF_PC,
  output logic            valid_3_IF_PC
);

  logic            v1, v2, v3;
  logic [31:0]     pc1, pc2, pc3;
  logic [DATA-1:0] inst2, inst3;
  logic            hold;
  logic            s2Load;

  assign hold   = Stall_ID_IF && v3;
  // A full S2 behind a held S3 cannot accept the returning word, so no new read.
  assign s2Load = !(v2 && hold);

  assign Rd_IF_ICache   = rst_n && GRT_RR_IF && !Flush_PC_IF && s2Load;
  assign Addr_IF_ICache = PC_in_IF_PC[ADDR+1:2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      pc1   <= '0;
      pc2   <= '0;
      pc3   <= '0;
      inst2 <= '0;
      inst3 <= '0;
    end else begin
      pc1 <= PC_in_IF_PC;
      if (s2Load) begin
        inst2 <= Data_ICache_IF;
        pc2   <= pc1;
      end
      if (!hold) begin
        inst3 <= inst2;
        pc3   <= pc2;
      end
      // Flush only clears the valid bits; the data path keeps moving harmlessly.
      if (Flush_PC_IF) begin
        v1 <= 1'b0;
        v2 <= 1'b0;
        v3 <= 1'b0;
      end else begin
        v1 <= Rd_IF_ICache;
        if (s2Load) v2 <= v1;
        if (!hold)  v3 <= v2;
      end
    end
  end

  assign Valid_IF_ID   = rst_n && v3 && !Flush_PC_IF;
  assign Inst_IF_ID    = inst3;
  assign PC_IF_ID      = pc3;
  assign valid_1_IF_PC = v1;
  assign valid_2_IF_PC = v2;
  assign valid_3_IF_PC = v3;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic, all checked
// against a queue-of-in-flight-fetches reference model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] PC_in_IF_PC;
  logic        GRT_RR_IF, Flush_PC_IF, Stall_ID_IF;
  logic [31:0] Data_ICache_IF;
  logic        Rd_IF_ICache;
  logic [11:0] Addr_IF_ICache;
  logic [31:0] Inst_IF_ID, PC_IF_ID;
  logic        Valid_IF_ID, valid_1_IF_PC, valid_2_IF_PC, valid_3_IF_PC;

  int nAssert = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  inst_fetch #(.DATA(32), .ADDR(12)) dut (
    .clk(clk), .rst_n(rst_n), .PC_in_IF_PC(PC_in_IF_PC), .GRT_RR_IF(GRT_RR_IF),
    .Flush_PC_IF(Flush_PC_IF), .Stall_ID_IF(Stall_ID_IF), .Data_ICache_IF(Data_ICache_IF),
    .Rd_IF_ICache(Rd_IF_ICache), .Addr_IF_ICache(Addr_IF_ICache), .Inst_IF_ID(Inst_IF_ID),
    .PC_IF_ID(PC_IF_ID), .Valid_IF_ID(Valid_IF_ID), .valid_1_IF_PC(valid_1_IF_PC),
    .valid_2_IF_PC(valid_2_IF_PC), .valid_3_IF_PC(valid_3_IF_PC)
  );

  // ICache word at word-address a is simply a; garbage when not read.
  function automatic logic [31:0] memWord(input logic [11:0] a);
    return {20'd0, a};
  endfunction

  always @(posedge clk) begin
    if (Rd_IF_ICache) Data_ICache_IF <= memWord(Addr_IF_ICache);
    else              Data_ICache_IF <= $urandom;
  end

  // Reference model: ordered list of live fetches, each tagged with its stage.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    int unsigned pos;
  } fetch_t;
  fetch_t q[$];
  logic [2:0]  occ;
  logic        expHold, expRd, regsZero;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelCheck();
    logic [31:0] outPc, outInst;
    occ = '0;
    outPc = '0;
    outInst = '0;
    foreach (q[i]) begin
      occ[q[i].pos-1] = 1'b1;
      if (q[i].pos == 3) begin
        outPc = q[i].pc;
        outInst = q[i].inst;
      end
    end
    expHold = Stall_ID_IF && occ[2];
    expRd   = rst_n && GRT_RR_IF && !Flush_PC_IF && !(occ[1] && expHold);
    chk("rd", {31'd0, Rd_IF_ICache}, {31'd0, expRd});
    chk("valid", {31'd0, Valid_IF_ID}, {31'd0, rst_n && occ[2] && !Flush_PC_IF});
    chk("occupancy", {29'd0, valid_3_IF_PC, valid_2_IF_PC, valid_1_IF_PC}, {29'd0, occ});
    chk("addr", {20'd0, Addr_IF_ICache}, {20'd0, PC_in_IF_PC[13:2]});
    if (rst_n && occ[2] && !Flush_PC_IF) begin
      chk("pc_out", PC_IF_ID, outPc);
      chk("inst_out", Inst_IF_ID, outInst);
    end
    if (!rst_n && regsZero) begin
      chk("rst_pc", PC_IF_ID, 32'd0);
      chk("rst_inst", Inst_IF_ID, 32'd0);
    end
  endtask

  task automatic modelUpdate();
    fetch_t nq[$];
    fetch_t e;
    regsZero = !rst_n;
    if (!rst_n || Flush_PC_IF) begin
      q.delete();
      return;
    end
    foreach (q[i]) begin
      e = q[i];
      if (e.pos == 3) begin
        if (expHold) nq.push_back(e);
      end else if (e.pos == 2) begin
        if (!expHold) e.pos = 3;
        nq.push_back(e);
      end else if (!(occ[1] && expHold)) begin
        e.pos = 2;
        e.inst = memWord(e.pc[13:2]);
        nq.push_back(e);
      end
    end
    if (expRd) begin
      e.pc = PC_in_IF_PC;
      e.inst = '0;
      e.pos = 1;
      nq.push_back(e);
    end
    q = nq;
  endtask

  task automatic cyc(input logic g, input logic s, input logic f, input logic r,
                     input logic [31:0] pc);
    GRT_RR_IF = g;
    Stall_ID_IF = s;
    Flush_PC_IF = f;
    rst_n = r;
    PC_in_IF_PC = pc;
    #1;
    modelCheck();
  endtask

  task automatic adv();
    @(posedge clk);
    modelUpdate();
    #1;
  endtask

  task automatic step(input logic g, input logic s, input logic f, input logic r,
                      input logic [31:0] pc);
    cyc(g, s, f, r, pc);
    adv();
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b1, base + 32'(4 * i));
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    GRT_RR_IF = 1'b0;
    Stall_ID_IF = 1'b0;
    Flush_PC_IF = 1'b0;
    PC_in_IF_PC = '0;
    @(posedge clk);
    q.delete();
    regsZero = 1'b1;
    #1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);

    // Stream: three back-to-back fetches appear three cycles after the first read.
    fill(32'h100);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h10C);
    chk("stream_pc0", PC_IF_ID, 32'h100);
    chk("stream_inst0", Inst_IF_ID, 32'h40);
    adv();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h10C);
    chk("stream_pc1", PC_IF_ID, 32'h104);
    chk("stream_inst1", Inst_IF_ID, 32'h41);
    adv();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h10C);
    chk("stream_pc2", PC_IF_ID, 32'h108);
    chk("stream_inst2", Inst_IF_ID, 32'h42);
    adv();
    drain();

    // Stall with full pipe: S1 dropped, then 0x104 and the refetched 0x108.
    fill(32'h100);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b1, 32'h10C);
      chk("stall_pc", PC_IF_ID, 32'h100);
      chk("stall_rd", {31'd0, Rd_IF_ICache}, 32'd0);
      chk("stall_v2", {31'd0, valid_2_IF_PC}, 32'd1);
      adv();
    end
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h108);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h10C);
    chk("resume_pc", PC_IF_ID, 32'h104);
    adv();
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h10C);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h10C);
    chk("refetch_pc", PC_IF_ID, 32'h108);
    adv();
    drain();

    // Flush with full pipe, then a new stream.
    fill(32'h100);
    step(1'b1, 1'b0, 1'b1, 1'b1, 32'h10C);
    fill(32'h200);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
    chk("post_flush_pc", PC_IF_ID, 32'h200);
    adv();
    drain();

    // Flush and stall together; stall lingers after the flush.
    fill(32'h100);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h10C);
    step(1'b0, 1'b1, 1'b0, 1'b1, 32'h10C);
    drain();

    // Grant gap 1,0,1.
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h300);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h304);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h304);
    drain();

    // Reset mid-stream with grant still asserted.
    fill(32'h400);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h40C);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h40C);
    step(1'b0, 1'b0, 1'b0, 1'b1, 32'h40C);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h40C);
    drain();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) == 0,
           $urandom_range(0, 29) != 0, $urandom & 32'hFFFF_FFFC);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
